// File: rtl/stack_pkg.sv
// Shared definitions for the stack / call-return sequencer: op codes, FSM
// state encoding, the default empty-stack SP and the latched request layout.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

    // Empty-stack SP; the stack grows downward from here toward STACK_FULL_SP.
    localparam logic [7:0] STACK_DEPTH_TOP = 8'hFF;
    localparam logic [7:0] STACK_FULL_SP   = 8'h00;

    typedef struct packed {
        op_e        op;
        logic [7:0] wdat;
        logic [7:0] sp;
    } req_t;

    function automatic logic op_is_write(input op_e o);
        return (o == OP_PUSH) || (o == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer for PUSH/POP/CALL/RET: done 2 cycles after acceptance for PUSH/CALL, 3 for POP/RET, 1 on full/empty.
// No backpressure: op_valid is sampled only in IDLE and silently dropped while busy.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter logic [7:0] DEPTH_TOP = STACK_DEPTH_TOP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [1:0] op,
    input  logic [7:0] push_data,
    input  logic [7:0] ret_pc,
    input  logic [7:0] sp_in,
    input  logic [7:0] mem_rdata,
    output logic       writeSP,
    output logic [7:0] sp_next,
    output logic       isPOP,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    output logic       busy,
    output logic       done,
    output logic [7:0] pop_data,
    output logic       pc_load,
    output logic [7:0] pc_out,
    output logic       overflow,
    output logic       underflow
);

    state_e     state_q, state_d;
    req_t       req_q, req_d;
    logic       err_q, err_d;
    logic [7:0] pop_data_q, pop_data_d;
    op_e        op_in;
    logic       in_write;

    assign op_in    = op_e'(op);
    assign in_write = op_is_write(op_in);
    assign pop_data = pop_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            err_q      <= 1'b0;
            pop_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            err_q      <= err_d;
            pop_data_q <= pop_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        err_d      = err_q;
        pop_data_d = pop_data_q;
        writeSP    = 1'b0;
        sp_next    = 8'h00;
        isPOP      = 1'b0;
        mem_addr   = 8'h00;
        mem_wdata  = 8'h00;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        pc_load    = 1'b0;
        pc_out     = 8'h00;
        overflow   = 1'b0;
        underflow  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    req_d.op   = op_in;
                    req_d.sp   = sp_in;
                    req_d.wdat = (op_in == OP_CALL) ? ret_pc : push_data;
                    // Full/empty is decided at acceptance so the SP never wraps.
                    if (in_write) begin
                        err_d   = (sp_in == STACK_FULL_SP);
                        state_d = err_d ? ST_FINISH : ST_WRITE;
                    end else begin
                        err_d   = (sp_in == DEPTH_TOP);
                        state_d = err_d ? ST_FINISH : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = req_q.sp;
                mem_wdata = req_q.wdat;
                writeSP   = 1'b1;
                sp_next   = req_q.sp - 8'd1;
                state_d   = ST_FINISH;
            end
            ST_READ: begin
                mem_re   = 1'b1;
                mem_addr = req_q.sp + 8'd1;
                writeSP  = 1'b1;
                isPOP    = 1'b1;
                sp_next  = req_q.sp + 8'd1;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pop_data_d = mem_rdata;
                state_d    = ST_FINISH;
            end
            ST_FINISH: begin
                done      = 1'b1;
                overflow  = err_q && op_is_write(req_q.op);
                underflow = err_q && !op_is_write(req_q.op);
                if ((req_q.op == OP_RET) && !err_q) begin
                    pc_load = 1'b1;
                    pc_out  = pop_data_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios plus randomized ops
// checked against an array-based stack model.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam logic [7:0] TOP = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [1:0] op;
    logic [7:0] push_data, ret_pc, sp_in, mem_rdata;
    logic       writeSP, isPOP, mem_we, mem_re, busy, done, pc_load, overflow, underflow;
    logic [7:0] sp_next, mem_addr, mem_wdata, pop_data, pc_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] env_mem [256];
    logic [7:0] mdl_mem [256];
    logic [7:0] mdl_sp, mdl_pop;

    int         obs_cycles, obs_we, obs_re, obs_wsp, obs_ispop, obs_pcl, obs_gate;
    logic [7:0] obs_addr, obs_wdata, obs_spnext, obs_pop, obs_pcout;
    logic       obs_ovf, obs_udf, obs_pcload, obs_after;

    int         exp_cycles, exp_we, exp_re, exp_wsp, exp_pcl;
    logic [7:0] exp_addr, exp_wdata, exp_spnext, exp_pop, exp_pcout;
    logic       exp_ovf, exp_udf;

    stack_ctrl #(.DEPTH_TOP(TOP)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .push_data(push_data),
        .ret_pc(ret_pc), .sp_in(sp_in), .mem_rdata(mem_rdata), .writeSP(writeSP),
        .sp_next(sp_next), .isPOP(isPOP), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done), .pop_data(pop_data),
        .pc_load(pc_load), .pc_out(pc_out), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues one op and records what the DUT does until done (bounded to 8 cycles).
    // The bench also plays SP register and data memory from the observed strobes.
    task automatic do_op(input logic [1:0] o, input logic [7:0] pd, input logic [7:0] rp, input bit hold);
        bit         pend;
        logic [7:0] paddr;
        @(negedge clk);
        op_valid = 1'b1; op = o; push_data = pd; ret_pc = rp;
        obs_cycles = 99; obs_we = 0; obs_re = 0; obs_wsp = 0; obs_ispop = 0; obs_pcl = 0; obs_gate = 0;
        obs_addr = 8'h00; obs_wdata = 8'h00; obs_spnext = 8'h00; obs_pop = 8'h00; obs_pcout = 8'h00;
        obs_ovf = 1'b0; obs_udf = 1'b0; obs_pcload = 1'b0;
        @(posedge clk);
        #1;
        if (hold) begin
            op = 2'b00; push_data = ~pd; ret_pc = ~rp; sp_in = sp_in ^ 8'h5A;
        end else begin
            op_valid = 1'b0;
        end
        pend  = 1'b0;
        paddr = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            mem_rdata = pend ? env_mem[paddr] : 8'($urandom);
            pend  = mem_re;
            paddr = mem_addr;
            if (mem_we) begin
                obs_we++; obs_addr = mem_addr; obs_wdata = mem_wdata; env_mem[mem_addr] = mem_wdata;
            end
            if (mem_re) begin
                obs_re++; obs_addr = mem_addr;
            end
            if (writeSP) begin
                obs_wsp++; obs_spnext = sp_next;
            end
            if (isPOP) obs_ispop++;
            if (pc_load) obs_pcl++;
            if ((!mem_we && !mem_re && mem_addr != 8'h00) || (!mem_we && mem_wdata != 8'h00) ||
                (!writeSP && (sp_next != 8'h00 || isPOP)) || (!pc_load && pc_out != 8'h00) ||
                (!done && (overflow || underflow || pc_load)) || !busy)
                obs_gate++;
            if (done) begin
                obs_cycles = c; obs_pop = pop_data; obs_ovf = overflow; obs_udf = underflow;
                obs_pcload = pc_load; obs_pcout = pc_out;
                op_valid = 1'b0;
                break;
            end
        end
        op_valid = 1'b0;
        if (hold) sp_in = sp_in ^ 8'h5A;
        @(posedge clk);
        #1;
        obs_after = done | busy | mem_we | mem_re | writeSP;
        if (obs_wsp != 0) sp_in = obs_spnext;
    endtask

    // Reference: a plain array stack with an SP that refuses to move past either end.
    task automatic model_op(input logic [1:0] o, input logic [7:0] pd, input logic [7:0] rp);
        exp_we = 0; exp_re = 0; exp_wsp = 0; exp_pcl = 0; exp_ovf = 1'b0; exp_udf = 1'b0;
        exp_addr = 8'h00; exp_wdata = 8'h00; exp_spnext = 8'h00; exp_pcout = 8'h00;
        if (o == 2'b00 || o == 2'b10) begin
            if (mdl_sp == 8'h00) begin
                exp_cycles = 1; exp_ovf = 1'b1;
            end else begin
                exp_cycles = 2; exp_we = 1; exp_wsp = 1; exp_addr = mdl_sp;
                exp_wdata  = (o == 2'b10) ? rp : pd;
                mdl_mem[mdl_sp] = exp_wdata;
                mdl_sp     = mdl_sp - 8'd1;
                exp_spnext = mdl_sp;
            end
        end else begin
            if (mdl_sp == TOP) begin
                exp_cycles = 1; exp_udf = 1'b1;
            end else begin
                exp_cycles = 3; exp_re = 1; exp_wsp = 1;
                mdl_sp     = mdl_sp + 8'd1;
                exp_addr   = mdl_sp; exp_spnext = mdl_sp;
                mdl_pop    = mdl_mem[mdl_sp];
                if (o == 2'b11) begin
                    exp_pcl = 1; exp_pcout = mdl_pop;
                end
            end
        end
        exp_pop = mdl_pop;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({writeSP, isPOP, mem_we, mem_re, busy, done, pc_load, overflow, underflow} !== 9'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 0", {writeSP, isPOP, mem_we, mem_re, busy, done, pc_load, overflow, underflow});
        end
        checks++;
        if ({pop_data, pc_out, mem_addr, mem_wdata, sp_next} !== 40'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {pop_data, pc_out, mem_addr, mem_wdata, sp_next});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_push_pop();
        sp_in = 8'hFF;
        do_op(2'b00, 8'hA5, 8'h00, 1'b0);
        checks++;
        if (obs_cycles !== 2 || obs_we !== 1 || obs_wsp !== 1) begin
            errors++; $display("FAIL push_timing got cyc=%0d we=%0d wsp=%0d exp 2/1/1", obs_cycles, obs_we, obs_wsp);
        end
        checks++;
        if ({obs_addr, obs_wdata, obs_spnext} !== {8'hFF, 8'hA5, 8'hFE}) begin
            errors++; $display("FAIL push_values got %h/%h/%h exp ff/a5/fe", obs_addr, obs_wdata, obs_spnext);
        end
        do_op(2'b01, 8'h00, 8'h00, 1'b0);
        checks++;
        if (obs_cycles !== 3 || obs_re !== 1 || obs_ispop !== 1 || obs_we !== 0) begin
            errors++; $display("FAIL pop_timing got cyc=%0d re=%0d ispop=%0d we=%0d exp 3/1/1/0", obs_cycles, obs_re, obs_ispop, obs_we);
        end
        checks++;
        if ({obs_addr, obs_spnext, obs_pop} !== {8'hFF, 8'hFF, 8'hA5}) begin
            errors++; $display("FAIL pop_values got %h/%h/%h exp ff/ff/a5", obs_addr, obs_spnext, obs_pop);
        end
    endtask

    task automatic test_call_ret();
        sp_in = 8'hF0;
        do_op(2'b10, 8'h99, 8'h42, 1'b0);
        checks++;
        if (obs_cycles !== 2 || {obs_addr, obs_wdata, obs_spnext} !== {8'hF0, 8'h42, 8'hEF} || env_mem[8'hF0] !== 8'h42) begin
            errors++; $display("FAIL call got cyc=%0d %h/%h/%h mem=%h exp 2 f0/42/ef mem=42",
                               obs_cycles, obs_addr, obs_wdata, obs_spnext, env_mem[8'hF0]);
        end
        do_op(2'b11, 8'h00, 8'h00, 1'b0);
        checks++;
        if (obs_cycles !== 3 || obs_pcload !== 1'b1 || obs_pcout !== 8'h42 || obs_pcl !== 1) begin
            errors++; $display("FAIL ret got cyc=%0d pc_load=%b pc_out=%h n=%0d exp 3 1 42 1", obs_cycles, obs_pcload, obs_pcout, obs_pcl);
        end
    endtask

    task automatic test_underflow();
        sp_in = 8'hFF;
        do_op(2'b01, 8'h00, 8'h00, 1'b0);
        checks++;
        if (obs_cycles !== 1 || obs_udf !== 1'b1 || obs_ovf !== 1'b0 || obs_re !== 0 || obs_wsp !== 0 || obs_pop !== 8'h42) begin
            errors++; $display("FAIL underflow_pop got cyc=%0d udf=%b ovf=%b re=%0d wsp=%0d pop=%h exp 1 1 0 0 0 42",
                               obs_cycles, obs_udf, obs_ovf, obs_re, obs_wsp, obs_pop);
        end
        do_op(2'b11, 8'h00, 8'h00, 1'b0);
        checks++;
        if (obs_cycles !== 1 || obs_udf !== 1'b1 || obs_pcl !== 0 || obs_gate !== 0) begin
            errors++; $display("FAIL underflow_ret got cyc=%0d udf=%b pcl=%0d gate=%0d exp 1 1 0 0", obs_cycles, obs_udf, obs_pcl, obs_gate);
        end
    endtask

    task automatic test_overflow();
        sp_in = 8'h00;
        do_op(2'b00, 8'h77, 8'h00, 1'b0);
        checks++;
        if (obs_cycles !== 1 || obs_ovf !== 1'b1 || obs_udf !== 1'b0 || obs_we !== 0 || obs_wsp !== 0) begin
            errors++; $display("FAIL overflow_push got cyc=%0d ovf=%b udf=%b we=%0d wsp=%0d exp 1 1 0 0 0",
                               obs_cycles, obs_ovf, obs_udf, obs_we, obs_wsp);
        end
        do_op(2'b10, 8'h00, 8'h31, 1'b0);
        checks++;
        if (obs_cycles !== 1 || obs_ovf !== 1'b1 || obs_we !== 0 || sp_in !== 8'h00) begin
            errors++; $display("FAIL overflow_call got cyc=%0d ovf=%b we=%0d sp=%h exp 1 1 0 00", obs_cycles, obs_ovf, obs_we, sp_in);
        end
    endtask

    task automatic test_busy_ignore();
        sp_in = 8'h80;
        do_op(2'b01, 8'h00, 8'h00, 1'b1);
        checks++;
        if (obs_cycles !== 3 || obs_we !== 0 || obs_re !== 1 || obs_addr !== 8'h81 || obs_after !== 1'b0) begin
            errors++; $display("FAIL busy_ignore got cyc=%0d we=%0d re=%0d addr=%h after=%b exp 3 0 1 81 0",
                               obs_cycles, obs_we, obs_re, obs_addr, obs_after);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        sp_in = 8'hFE;
        @(negedge clk);
        op_valid = 1'b1; op = 2'b01;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({writeSP, isPOP, mem_we, mem_re, busy, done, pc_load, overflow, underflow, pop_data, pc_out, mem_addr, sp_next} !== 41'h0) begin
            errors++; $display("FAIL reset_mid got busy=%b done=%b wsp=%b pop=%h addr=%h exp all 0", busy, done, writeSP, pop_data, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done || busy || writeSP) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", bad);
        end
        do_op(2'b00, 8'h3C, 8'h00, 1'b0);
        checks++;
        if (obs_cycles !== 2 || {obs_addr, obs_wdata, obs_spnext} !== {8'hFE, 8'h3C, 8'hFD}) begin
            errors++; $display("FAIL push_after_reset got cyc=%0d %h/%h/%h exp 2 fe/3c/fd", obs_cycles, obs_addr, obs_wdata, obs_spnext);
        end
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [7:0] pd, rp, v;
        bit         hold;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            env_mem[i] = v;
            mdl_mem[i] = v;
        end
        apply_reset();
        sp_in = TOP; mdl_sp = TOP; mdl_pop = 8'h00;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: v = 8'h00;
                    1: v = 8'h01;
                    2: v = 8'hFE;
                    3: v = 8'hFF;
                    default: v = 8'($urandom);
                endcase
                sp_in = v; mdl_sp = v;
            end
            o = 2'($urandom_range(0, 3)); pd = 8'($urandom); rp = 8'($urandom); hold = 1'($urandom_range(0, 1));
            model_op(o, pd, rp);
            do_op(o, pd, rp, hold);
            checks++;
            if (obs_cycles !== exp_cycles) begin
                errors++; $display("FAIL rnd%0d latency got %0d exp %0d (op %0d)", i, obs_cycles, exp_cycles, o);
            end
            checks++;
            if ({obs_we, obs_re, obs_wsp, obs_ispop, obs_pcl} !== {exp_we, exp_re, exp_wsp, exp_re, exp_pcl}) begin
                errors++; $display("FAIL rnd%0d strobes got we%0d re%0d wsp%0d ip%0d pcl%0d exp we%0d re%0d wsp%0d ip%0d pcl%0d",
                                   i, obs_we, obs_re, obs_wsp, obs_ispop, obs_pcl, exp_we, exp_re, exp_wsp, exp_re, exp_pcl);
            end
            checks++;
            if ({obs_addr, obs_wdata, obs_spnext} !== {exp_addr, exp_wdata, exp_spnext}) begin
                errors++; $display("FAIL rnd%0d addr/wdata/sp_next got %h/%h/%h exp %h/%h/%h",
                                   i, obs_addr, obs_wdata, obs_spnext, exp_addr, exp_wdata, exp_spnext);
            end
            checks++;
            if ({obs_pop, obs_pcout, obs_pcload, obs_ovf, obs_udf} !== {exp_pop, exp_pcout, exp_pcl == 1, exp_ovf, exp_udf}) begin
                errors++; $display("FAIL rnd%0d finish got pop=%h pc=%h pcl=%b ovf=%b udf=%b exp pop=%h pc=%h pcl=%0d ovf=%b udf=%b",
                                   i, obs_pop, obs_pcout, obs_pcload, obs_ovf, obs_udf, exp_pop, exp_pcout, exp_pcl, exp_ovf, exp_udf);
            end
            checks++;
            if (obs_gate !== 0 || obs_after !== 1'b0) begin
                errors++; $display("FAIL rnd%0d gating got %0d bad cycles, after_done=%b exp 0/0", i, obs_gate, obs_after);
            end
            checks++;
            if (sp_in !== mdl_sp) begin
                errors++; $display("FAIL rnd%0d sp got %h exp %h", i, sp_in, mdl_sp);
            end
        end
    endtask

    initial begin
        op_valid = 1'b0; op = 2'b00; push_data = 8'h00; ret_pc = 8'h00;
        sp_in = TOP; mem_rdata = 8'h00; rst = 1'b1;
        for (int i = 0; i < 256; i++) env_mem[i] = 8'h00;
        #2;
        test_reset();
        test_push_pop();
        test_call_ret();
        test_underflow();
        test_overflow();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH_TOP, default 8'hFF, meaning the empty-stack SP value; the stack grows downward from it.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, the reset, asynchronous and active-low.
REQ-004 The module SHALL have port op_valid, input, 1, the operation request, sampled in IDLE only.
REQ-005 The module SHALL have port op, input, 2, the operation code: 00 PUSH, 01 POP, 10 CALL, 11 RET.
REQ-006 The module SHALL have port push_data, input, 8, the PUSH operand.
REQ-007 The module SHALL have port ret_pc, input, 8, the return address saved by CALL.
REQ-008 The module SHALL have port sp_in, input, 8, the current SP from the stack pointer register.
REQ-009 The module SHALL have port mem_rdata, input, 8, the data-memory read data, valid one cycle after mem_re.
REQ-010 The module SHALL have outputs writeSP (1), sp_next (8) and isPOP (1), the SP update controls.
REQ-011 The module SHALL have outputs mem_addr (8), mem_wdata (8), mem_we (1) and mem_re (1), the data-memory port.
REQ-012 The module SHALL have outputs busy (1), done (1), pop_data (8), pc_load (1), pc_out (8), overflow (1) and underflow (1).

Function
REQ-013 The FSM SHALL have the states IDLE, WRITE, READ, CAPTURE and FINISH; busy SHALL be 1 in every state except IDLE.
REQ-014 The FSM SHALL accept an operation in IDLE when op_valid=1, latching op, push_data, ret_pc and sp_in into internal registers.
REQ-015 PUSH and CALL: IDLE->WRITE->FINISH; in WRITE, mem_we=1, mem_addr=latched SP, mem_wdata=push_data (PUSH) or ret_pc (CALL), writeSP=1, sp_next=SP-1.
REQ-016 POP and RET: IDLE->READ->CAPTURE->FINISH; in READ, mem_re=1, mem_addr=SP+1, writeSP=1, isPOP=1, sp_next=SP+1.
REQ-017 In CAPTURE, the FSM SHALL register mem_rdata into pop_data, which then holds until the next POP or RET capture.
REQ-018 FINISH SHALL pulse done for exactly one cycle and then return to IDLE; a RET SHALL also pulse pc_load with pc_out=pop_data in the same cycle.
REQ-019 Latency SHALL be 2 cycles from acceptance to done for PUSH and CALL, and 3 cycles for POP and RET.
REQ-020 Full: a PUSH or CALL with latched SP=8'h00 SHALL go IDLE->FINISH with no mem_we and no writeSP, and pulse overflow together with done.
REQ-021 Empty: a POP or RET with latched SP=DEPTH_TOP SHALL go IDLE->FINISH with no mem_re and no writeSP, pulse underflow with done, leave pop_data unchanged, and raise no pc_load.
REQ-022 SP arithmetic SHALL be 8-bit; because of REQ-020 and REQ-021, wrap-around SHALL never be produced.
REQ-023 op_valid while busy SHALL be ignored; no queuing.
REQ-024 Outputs not named active in a state SHALL be 0 there; mem_addr, mem_wdata, sp_next and pc_out SHALL be 0 when their strobe is 0.

Reset
REQ-025 Asserting rst in any state SHALL immediately force IDLE and drive every strobe, flag, pop_data and pc_out to 0; an in-flight operation SHALL be abandoned with no writeSP.
REQ-026 After rst deasserts, the first op_valid SHALL be accepted on the next rising edge.

Structure
REQ-027 Op codes, the state encoding and DEPTH_TOP SHALL live in the shared package stack_pkg.
REQ-028 The design SHALL be a single module with no sub-module; the FSM and the datapath registers are co-located.

Verification
REQ-029 Reset then PUSH 8'hA5 with sp_in=FF -> WRITE: mem_addr=FF, mem_wdata=A5, sp_next=FE; done 2 cycles after acceptance.
REQ-030 POP with sp_in=FE and mem_rdata=A5 -> mem_addr=FF, isPOP=1, sp_next=FF; pop_data=A5 at done, 3 cycles after acceptance.
REQ-031 CALL ret_pc=8'h42 at SP=F0, then RET at SP=EF -> mem[F0]=42 written; pc_load pulse with pc_out=42.
REQ-032 POP at sp_in=FF -> underflow and done in the same cycle; no mem_re, no writeSP, pop_data unchanged.
REQ-033 PUSH at sp_in=00 -> overflow pulse; no mem_we, no writeSP.
REQ-034 rst asserted during CAPTURE of a POP -> all outputs 0 immediately, no done; a following PUSH completes normally.
